// File: rtl/pokey_poly_gen.sv
// POKEY-style polynomial noise generator: XNOR-feedback LFSR with a long/short
// field, lock-up recovery, an init clear path and a delayed serial output.
module pokey_poly_gen #(
    parameter int              W          = 17,
    parameter int              SHORT_W    = 9,
    parameter int              TAP_A      = 0,
    parameter int              TAP_B      = 3,
    parameter int              STAP_A     = 0,
    parameter int              STAP_B     = 4,
    parameter int              OUT_W      = 8,
    parameter int              DELAY      = 1,
    parameter logic [W-1:0]    RESET_SEED = 17'h0AAAA
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               mode,
    input  logic               init,
    input  logic               seed_load,
    input  logic [W-1:0]       seed,
    output logic               bit_out,
    output logic [OUT_W-1:0]   rand_out,
    output logic               lockup
);

    logic [W-1:0]     r_s;
    logic             r_mode_del;
    logic             r_lockup;
    logic [DELAY-1:0] r_pipe;

    logic             w_lock_long;
    logic             w_lock_short;
    logic             w_lock;
    logic             w_fb_long;
    logic             w_fb_short;
    logic             w_fb;
    logic             w_ins;
    logic [W-1:0]     w_s_long;
    logic [W-1:0]     w_s_short;
    logic [W-1:0]     w_s_step;
    logic [DELAY-1:0] w_pipe_in;
    logic             w_advance;

    // XNOR feedback makes all-ones (not all-zeros) the stuck state.
    always_comb begin
        w_lock_long  = &r_s;
        w_lock_short = &r_s[SHORT_W-1:0];
        w_lock       = r_mode_del ? w_lock_short : w_lock_long;
        w_fb_long    = ~(r_s[TAP_A] ^ r_s[TAP_B]);
        w_fb_short   = ~(r_s[STAP_A] ^ r_s[STAP_B]);
        w_fb         = r_mode_del ? w_fb_short : w_fb_long;
        w_ins        = (init || w_lock) ? 1'b0 : w_fb;
    end

    // Short mode shifts only the low field; the upper bits are left intact.
    always_comb begin
        w_s_long                   = {w_ins, r_s[W-1:1]};
        w_s_short                  = r_s;
        w_s_short[SHORT_W-1:0]     = {w_ins, r_s[SHORT_W-1:1]};
        w_s_step                   = r_mode_del ? w_s_short : w_s_long;
    end

    assign w_advance = enable && !seed_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s        <= RESET_SEED;
            r_mode_del <= 1'b0;
            r_lockup   <= 1'b0;
        end else if (seed_load) begin
            r_s      <= seed;
            r_lockup <= 1'b0;
        end else if (enable) begin
            r_s        <= w_s_step;
            r_mode_del <= mode;
            r_lockup   <= w_lock && !init;
        end else begin
            r_lockup <= 1'b0;
        end
    end

    // Serial delay line: stage 0 samples s[0], later stages chain behind it.
    genvar gi;
    generate
        for (gi = 0; gi < DELAY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign w_pipe_in[gi] = r_s[0];
            end else begin : g_tail
                assign w_pipe_in[gi] = r_pipe[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else if (w_advance) begin
            r_pipe <= w_pipe_in;
        end
    end

    assign bit_out  = r_pipe[DELAY-1];
    assign rand_out = ~r_s[OUT_W-1:0];
    assign lockup   = r_lockup;

endmodule

// File: tb/tb_pokey_poly_gen.sv
// Self-checking bench for pokey_poly_gen: directed scenarios plus randomized
// streaming against an arithmetic reference model of the polynomial rules.
module tb_pokey_poly_gen;

    localparam int MW   = 17;
    localparam int MSW  = 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0, sl = 1'b0, md = 1'b0, ini = 1'b0;
    logic [16:0] sd = '0;
    logic        bit_o, lk_o;
    logic [7:0]  rnd_o;

    logic        b_en = 1'b0, b_sl = 1'b0, b_md = 1'b0, b_ini = 1'b0;
    logic [9:0]  b_sd = '0;
    logic        b_bit, b_lk;
    logic [3:0]  b_rnd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pokey_poly_gen dut (
        .clk(clk), .reset_n(reset_n), .enable(en), .mode(md), .init(ini),
        .seed_load(sl), .seed(sd), .bit_out(bit_o), .rand_out(rnd_o), .lockup(lk_o)
    );

    pokey_poly_gen #(
        .W(10), .SHORT_W(5), .TAP_A(0), .TAP_B(3), .STAP_A(0), .STAP_B(2),
        .OUT_W(4), .DELAY(2), .RESET_SEED(10'h155)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(b_en), .mode(b_md), .init(b_ini),
        .seed_load(b_sl), .seed(b_sd), .bit_out(b_bit), .rand_out(b_rnd), .lockup(b_lk)
    );

    // Reference model state
    longint m_s;
    bit     m_md;
    bit     m_lk;
    bit     m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_s  = 17'h0AAAA;
        m_md = 1'b0;
        m_lk = 1'b0;
        m_q  = {};
        m_q.push_back(1'b0);
    endtask

    // One clock of the generator, described as arithmetic on the active field.
    task automatic m_step(input bit e, input bit l, input longint seedv, input bit mo, input bit it);
        longint n, ta, tb, field, upper, full;
        bit locked, fb, ins;
        if (l) begin
            m_s  = seedv;
            m_lk = 1'b0;
        end else if (e) begin
            n      = m_md ? MSW : MW;
            ta     = 0;
            tb     = m_md ? 4 : 3;
            full   = longint'(1) << n;
            field  = m_s % full;
            upper  = m_s - field;
            locked = (field == full - 1);
            fb     = (((field >> ta) & 1) == ((field >> tb) & 1));
            ins    = (it || locked) ? 1'b0 : fb;
            m_q.push_back(bit'(m_s % 2));
            void'(m_q.pop_front());
            m_s  = upper + field / 2 + (ins ? (full / 2) : 0);
            m_md = mo;
            m_lk = locked && !it;
        end else begin
            m_lk = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_s"},    32'(dut.r_s), 32'(m_s));
        chk({tag, "_rand"}, 32'(rnd_o),   32'((~m_s) & 8'hFF));
        chk({tag, "_bit"},  32'(bit_o),   32'(m_q[0]));
        chk({tag, "_lock"}, 32'(lk_o),    32'(m_lk));
    endtask

    task automatic cyc(input bit e, input bit l, input logic [16:0] s_in,
                       input bit mo, input bit it, input string tag);
        en = e; sl = l; sd = s_in; md = mo; ini = it;
        @(posedge clk); #1;
        m_step(e, l, longint'(s_in), mo, it);
        check_all(tag);
    endtask

    initial begin
        logic [8:0]  start_low;
        logic [16:0] rs;
        logic [9:0]  b_start;
        int          first_ret;
        bit          ones_seen;
        bit          lk_seen;

        m_reset();
        #12;
        check_all("reset");
        chk("reset_rand55", 32'(rnd_o), 32'h55);
        reset_n = 1'b1;

        // First step after reset in long mode
        cyc(1, 0, '0, 0, 0, "first");
        chk("first_s", 32'(dut.r_s), 32'h05555);
        chk("first_rand", 32'(rnd_o), 32'hAA);
        chk("first_bit", 32'(bit_o), 32'h0);

        // Long-mode lock-up recovery
        cyc(0, 1, 17'h1FFFF, 0, 0, "ld_ones");
        cyc(1, 0, '0, 0, 0, "lock_step");
        chk("lock_s", 32'(dut.r_s), 32'h0FFFF);
        chk("lock_pulse", 32'(lk_o), 32'h1);
        cyc(0, 0, '0, 0, 0, "lock_idle");
        chk("lock_clear", 32'(lk_o), 32'h0);

        // init clears the register, then feedback of zeros inserts a one
        for (int i = 0; i < 17; i++) cyc(1, 0, '0, 0, 1, "init");
        chk("init_zero", 32'(dut.r_s), 32'h00000);
        cyc(1, 0, '0, 0, 0, "init_rel");
        chk("init_fb1", 32'(dut.r_s), 32'h10000);

        // seed_load wins over enable; mode_del and pipe hold
        cyc(1, 1, 17'h12345, 1, 0, "ld_pri");
        chk("ld_pri_s", 32'(dut.r_s), 32'h12345);

        // Short-mode period: mode_del already 1 via a prior enable
        cyc(1, 0, '0, 1, 0, "sh_arm");
        cyc(0, 1, 17'h1AB01, 1, 0, "sh_ld");
        cyc(1, 0, '0, 1, 0, "sh_pre0");
        cyc(1, 0, '0, 1, 0, "sh_pre1");
        chk("sh_upper_pre", 32'(dut.r_s[16:9]), 32'h0D5);
        start_low = dut.r_s[8:0];
        ones_seen = 1'b0;
        lk_seen   = 1'b0;
        for (int i = 0; i < 511; i++) begin
            en = 1; sl = 0; md = 1; ini = 0;
            @(posedge clk); #1;
            m_step(1, 0, 0, 1, 0);
            if (dut.r_s[8:0] == 9'h1FF) ones_seen = 1'b1;
            if (lk_o) lk_seen = 1'b1;
            chk("sh_upper", 32'(dut.r_s[16:9]), 32'h0D5);
        end
        chk("sh_period", 32'(dut.r_s[8:0]), 32'(start_low));
        chk("sh_no_ones", 32'(ones_seen), 32'h0);
        chk("sh_no_lock", 32'(lk_seen), 32'h0);
        check_all("sh_end");

        // Randomized streaming against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = 17'h1FFFF;
                1:       rs = 17'($urandom) | 17'h001FF;
                default: rs = 17'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rs,
                ($urandom_range(0, 7) == 0) ? ~md : md, $urandom_range(0, 15) == 0, "rnd");
        end

        // Asynchronous reset mid-stream
        en = 1; sl = 1; sd = 17'h1FFFF; md = 1; ini = 0;
        @(posedge clk); #1;
        m_step(1, 1, 17'h1FFFF, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("arst_s", 32'(dut.r_s), 32'h0AAAA);
        check_all("arst");
        @(posedge clk); #1;
        check_all("arst_hold");
        reset_n = 1'b1;
        cyc(1, 0, '0, 1, 0, "arst_rel");
        chk("arst_long", 32'(dut.r_s), 32'h05555);

        // Full long-mode period on a reduced-width instance
        en = 0; sl = 0;
        b_sl = 1; b_sd = 10'h001;
        @(posedge clk); #1;
        b_sl = 0; b_en = 1;
        b_start   = dut_b.r_s;
        first_ret = 0;
        ones_seen = 1'b0;
        lk_seen   = 1'b0;
        for (int i = 1; i <= 1023; i++) begin
            @(posedge clk); #1;
            if (dut_b.r_s == 10'h3FF) ones_seen = 1'b1;
            if (b_lk) lk_seen = 1'b1;
            if (dut_b.r_s == b_start && first_ret == 0) first_ret = i;
        end
        b_en = 0;
        chk("b_start", 32'(b_start), 32'h001);
        chk("b_period", 32'(first_ret), 32'd1023);
        chk("b_no_ones", 32'(ones_seen), 32'h0);
        chk("b_no_lock", 32'(lk_seen), 32'h0);
        chk("b_rand", 32'(b_rnd), 32'hE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
